// File: rtl/alu_result_bcd.sv
// Captures one ALU result and converts it to sign plus BCD digits for the display driver.
// Conversion is double dabble, one shift per clock. Divide results convert as two independent 2-digit values.
module alu_result_bcd #(
    parameter int WIDTH = 6
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           func,
    input  logic [2*WIDTH-1:0]   result,
    input  logic                 overflow,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          bcd,
    output logic                 neg_hi,
    output logic                 neg_lo,
    output logic                 ovf_out,
    output logic [1:0]           func_out
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(RW + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    localparam logic [1:0] F_MUL = 2'b10;
    localparam logic [1:0] F_DIV = 2'b11;

    logic [0:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   mag_q, mag_d;
    logic [15:0]     work_q, work_d;
    logic [1:0]      func_c_q, func_c_d;
    logic            ovf_c_q, ovf_c_d;
    logic            neg_hi_c_q, neg_hi_c_d;
    logic            neg_lo_c_q, neg_lo_c_d;

    logic [15:0]     bcd_q, bcd_d;
    logic            neg_hi_q, neg_hi_d;
    logic            neg_lo_q, neg_lo_d;
    logic            ovf_out_q, ovf_out_d;
    logic [1:0]      func_out_q, func_out_d;
    logic            done_q, done_d;

    logic [WIDTH-1:0] lo_fld, hi_fld;
    logic [WIDTH-1:0] lo_mag, hi_mag;
    logic [RW-1:0]    full_mag;
    logic [15:0]      adj;

    // Add 3 to every digit of 5 or more so the following shift carries correctly in decimal.
    function automatic logic [15:0] add3_digits(input logic [15:0] w);
        logic [15:0] r;
        r = w;
        for (int i = 0; i < 4; i++) begin
            if (w[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = w[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Two's complement magnitudes stay unsigned, so the most negative value maps to 2^(n-1).
    always_comb begin
        lo_fld   = result[WIDTH-1:0];
        hi_fld   = result[RW-1:WIDTH];
        lo_mag   = lo_fld[WIDTH-1] ? (~lo_fld + WIDTH'(1)) : lo_fld;
        hi_mag   = hi_fld[WIDTH-1] ? (~hi_fld + WIDTH'(1)) : hi_fld;
        full_mag = result[RW-1] ? (~result + RW'(1)) : result;
        adj      = add3_digits(work_q);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        work_d     = work_q;
        func_c_d   = func_c_q;
        ovf_c_d    = ovf_c_q;
        neg_hi_c_d = neg_hi_c_q;
        neg_lo_c_d = neg_lo_c_q;
        bcd_d      = bcd_q;
        neg_hi_d   = neg_hi_q;
        neg_lo_d   = neg_lo_q;
        ovf_out_d  = ovf_out_q;
        func_out_d = func_out_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CONV;
                    work_d   = '0;
                    func_c_d = func;
                    case (func)
                        F_MUL: begin
                            mag_d      = full_mag;
                            neg_hi_c_d = result[RW-1];
                            neg_lo_c_d = 1'b0;
                            ovf_c_d    = 1'b0;
                            cnt_d      = CW'(RW);
                        end
                        F_DIV: begin
                            mag_d      = {hi_mag, lo_mag};
                            neg_hi_c_d = hi_fld[WIDTH-1];
                            neg_lo_c_d = lo_fld[WIDTH-1];
                            ovf_c_d    = 1'b0;
                            cnt_d      = CW'(WIDTH);
                        end
                        default: begin
                            // Left-align so the shared MSB tap feeds the dabble register.
                            mag_d      = {lo_mag, {WIDTH{1'b0}}};
                            neg_hi_c_d = lo_fld[WIDTH-1];
                            neg_lo_c_d = 1'b0;
                            ovf_c_d    = overflow;
                            cnt_d      = CW'(WIDTH);
                        end
                    endcase
                end
            end

            S_CONV: begin
                if (func_c_q == F_DIV) begin
                    work_d = {adj[14:8], mag_q[RW-1], adj[6:0], mag_q[WIDTH-1]};
                    mag_d  = {mag_q[RW-2:WIDTH], 1'b0, mag_q[WIDTH-2:0], 1'b0};
                end else begin
                    work_d = {adj[14:0], mag_q[RW-1]};
                    mag_d  = {mag_q[RW-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);

                if (cnt_q == CW'(1)) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    bcd_d      = work_d;
                    neg_hi_d   = neg_hi_c_q;
                    neg_lo_d   = neg_lo_c_q;
                    ovf_out_d  = ovf_c_q;
                    func_out_d = func_c_q;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mag_q      <= '0;
            work_q     <= '0;
            func_c_q   <= '0;
            ovf_c_q    <= 1'b0;
            neg_hi_c_q <= 1'b0;
            neg_lo_c_q <= 1'b0;
            bcd_q      <= '0;
            neg_hi_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            ovf_out_q  <= 1'b0;
            func_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            work_q     <= work_d;
            func_c_q   <= func_c_d;
            ovf_c_q    <= ovf_c_d;
            neg_hi_c_q <= neg_hi_c_d;
            neg_lo_c_q <= neg_lo_c_d;
            bcd_q      <= bcd_d;
            neg_hi_q   <= neg_hi_d;
            neg_lo_q   <= neg_lo_d;
            ovf_out_q  <= ovf_out_d;
            func_out_q <= func_out_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == S_CONV);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign neg_hi   = neg_hi_q;
    assign neg_lo   = neg_lo_q;
    assign ovf_out  = ovf_out_q;
    assign func_out = func_out_q;

endmodule

// File: doc/alu_result_bcd.md
Name: alu_result_bcd

Overview:
- Sequential result formatter directly downstream of alu_top.
- Captures one ALU result with its func code and overflow flag, then converts it to sign plus BCD digits for the seven-segment display driver.
- Conversion is iterative shift-and-add-3 (double dabble), one shift per clock, with a start/busy/done handshake.

Parameters:
WIDTH, 6, ALU operand width; the result bus is 2*WIDTH. Only 6 is required; the BCD output is fixed at 4 digits.

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  capture request; sampled only while idle
func  input  2  ALU op: 00 add, 01 sub, 10 mul, 11 div
result  input  2*WIDTH  ALU out bus
overflow  input  1  ALU overflow flag
busy  output  1  conversion in progress
done  output  1  one-cycle pulse, outputs valid
bcd  output  16  4 BCD digits, [15:12] most significant
neg_hi  output  1  sign of the main value (add/sub/mul) or of the quotient (div)
neg_lo  output  1  sign of the remainder (div); 0 otherwise
ovf_out  output  1  captured overflow; forced 0 for mul/div
func_out  output  2  captured func

Behaviour:
- Clock port is clock; reset is synchronous, active-low, on reset_n. Everything is clocked on the rising edge of clock.
- Reset: at any edge with reset_n=0, state returns to IDLE and busy, done, bcd, neg_hi, neg_lo, ovf_out and func_out all clear to 0. This applies mid-conversion; the partial result is discarded.
- States: IDLE, CONV.
- IDLE -> CONV: on the edge where start=1. At that edge, func, overflow and result are captured, magnitudes are computed, the shift counter is loaded with N and busy goes to 1.
- Operand extraction (two's complement, sign = MSB of the field):
  - add/sub: signed field result[WIDTH-1:0], 6-bit magnitude, N=6.
  - mul: signed field result[2*WIDTH-1:0], 12-bit magnitude, N=12.
  - div: quotient field result[2*WIDTH-1:WIDTH] and remainder field result[WIDTH-1:0], each signed. Both convert in parallel in two independent 2-digit dabble registers, N=6.
- Magnitude of the most negative field value must be correct: -32 gives 32; 12-bit -2048 gives 2048.
- CONV, every edge:
  - Add 3 to each BCD digit >= 5.
  - Then shift the magnitude MSB into the BCD LSB.
  - Decrement the counter.
- On the edge performing the N-th shift:
  - bcd, neg_hi, neg_lo, ovf_out and func_out update.
  - done=1 for exactly that following cycle; busy=0; state returns to IDLE.
- Latency: start sampled at edge k gives done high in the cycle after edge k+N. busy is high in the cycles after edges k through k+N-1.
- Output mapping:
  - add/sub/mul: bcd holds the value zero-padded to 4 digits.
  - div: bcd[15:8] = quotient, bcd[7:0] = remainder.
- Zero magnitude gives neg=0 and bcd=0000; there is no negative zero.
- bcd, neg_hi, neg_lo, ovf_out and func_out hold their values until the next done or reset. They do not change while busy.
- start while busy is ignored. The captured operand is not altered even if result changes during CONV.
- start during the done cycle is in IDLE and is accepted, giving back-to-back conversions with no gap cycle.
- ovf_out is informational only: for add/sub overflow, digits show the wrapped 6-bit value.

Test Plan:
1. mul: result=12'h400 (-32*-32), start at edge k -> done in the cycle after edge k+12; bcd=16'h1024, neg_hi=0, ovf_out=0, func_out=2'b10.
2. mul: result=12'hC20 (-32*31=-992) -> bcd=16'h0992, neg_hi=1, neg_lo=0.
3. add: result[5:0]=6'b100000, overflow=1 -> done after 6 cycles; bcd=16'h0032, neg_hi=1, ovf_out=1. Then result=0 gives bcd=0000, neg_hi=0.
4. div: result=12'h1C3 (q=7, r=3) -> bcd=16'h0703, neg_hi=0, neg_lo=0, done after 6 cycles.
5. Handshake:
   - Pulse start again 3 cycles into a mul conversion, with result changed -> ignored; first result is unaffected.
   - Assert start in the done cycle -> second conversion starts immediately; its done arrives N cycles later.
6. Reset mid-conversion:
   - Drive reset_n low 5 cycles into a mul -> next cycle busy=0, done=0, bcd=0, all flags 0.
   - No done pulse follows.
   - A subsequent start converts normally.
